dae_instr_issuer: RTL and testbench

//  Sequencer driving the decode-and-execute unit: holds a small instruction program, issues {sel,rs,rt}
//  one instruction at a time, samples the returned rd, and presents it for display.

---
 rtl/dae_pkg.sv | 44 ++++
 rtl/dae_tick_counter.sv | 44 ++++
 rtl/dae_instr_issuer.sv | 212 +++++++++++++++++++++
 tb/tb_dae_instr_issuer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dae_pkg.sv
// dae_pkg: shared definitions for the decode-and-execute instruction issuer.
//   - opcode constants understood by the decode-and-execute unit
//   - instruction word layout {sel[10:8], rs[7:4], rt[3:0]} and field helpers
//   - issuer FSM state encoding
package dae_pkg;

  localparam int INSTR_W = 11;
  localparam int SEL_HI  = 10;
  localparam int SEL_LO  = 8;
  localparam int RS_HI   = 7;
  localparam int RS_LO   = 4;
  localparam int RT_HI   = 3;
  localparam int RT_LO   = 0;

  localparam logic [2:0] OP_SUB = 3'b000;  // rs - rt
  localparam logic [2:0] OP_ADD = 3'b001;  // rs + rt
  localparam logic [2:0] OP_OR  = 3'b010;  // rs | rt
  localparam logic [2:0] OP_AND = 3'b011;  // rs & rt
  localparam logic [2:0] OP_SRA = 3'b100;  // rt >>> 1
  localparam logic [2:0] OP_ROL = 3'b101;  // rs rotate-left 1
  localparam logic [2:0] OP_CLT = 3'b110;  // {101, rs < rt}
  localparam logic [2:0] OP_CEQ = 3'b111;  // {111, rs == rt}

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [2:0] instr_sel(input logic [INSTR_W-1:0] instr);
    return instr[SEL_HI:SEL_LO];
  endfunction

  function automatic logic [3:0] instr_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [3:0] instr_rt(input logic [INSTR_W-1:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/dae_tick_counter.sv
// dae_tick_counter: run-mode dwell counter.
//   clk, rst_n : clock, async active-low reset
//   en         : count while high
//   clr        : synchronous clear, overrides en
//   tc         : high during the last of TICK_CYCLES counted cycles
module dae_tick_counter
  import dae_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_r;
  logic          at_end_s;

  assign at_end_s = (cnt_r == CW'(TICK_CYCLES - 1));
  // A clear in the same cycle suppresses the terminal pulse.
  assign tc = en && !clr && at_end_s;

  // Dwell count: wraps to zero after the terminal cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (at_end_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/dae_instr_issuer.sv
// dae_instr_issuer: sequences a small program into the decode-and-execute unit.
//   Inputs : clk, rst_n, wr_en/wr_addr/wr_data (program load in IDLE), prog_last,
//            start, step, run_mode, stop, rd_in (unit result)
//   Outputs: rs, rt, sel (operands/opcode), issue_valid, result, result_valid,
//            pc, busy, done -- all registered.
// Flow: IDLE -> ISSUE -> WAIT (EXEC_LAT cycles) -> PAUSE -> ISSUE | DONE.
module dae_instr_issuer
  import dae_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = $clog2(DEPTH),
  parameter int TICK_CYCLES = 100_000_000,
  parameter int EXEC_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]     prog_last,
  input  logic              start,
  input  logic              step,
  input  logic              run_mode,
  input  logic              stop,
  input  logic [3:0]        rd_in,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [2:0]        sel,
  output logic              issue_valid,
  output logic [3:0]        result,
  output logic              result_valid,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done
);

  localparam int LW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  state_e               state_r;
  state_e               state_s;
  logic [INSTR_W-1:0]   mem_r [DEPTH];
  logic [LW-1:0]        lat_cnt_r;
  logic                 run_mode_r;
  logic [3:0]           rs_r;
  logic [3:0]           rt_r;
  logic [2:0]           sel_r;
  logic                 issue_valid_r;
  logic [3:0]           result_r;
  logic                 result_valid_r;
  logic [AW-1:0]        pc_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 lat_done_s;
  logic                 advance_s;
  logic                 tick_en_s;
  logic                 tick_clr_s;
  logic                 tick_tc_s;
  logic                 mem_we_s;
  logic                 load_s;
  logic                 sample_s;
  logic                 pc_clr_s;
  logic                 pc_inc_s;

  assign lat_done_s = (lat_cnt_r == LW'(EXEC_LAT - 1));
  // In run mode only the dwell tick advances; step is ignored.
  assign advance_s  = run_mode ? tick_tc_s : step;
  assign mem_we_s   = (state_r == ST_IDLE) && wr_en;
  // Dwell restarts whenever PAUSE is not active or run_mode flips.
  assign tick_en_s  = (state_r == ST_PAUSE) && run_mode;
  assign tick_clr_s = (state_r != ST_PAUSE) || (run_mode != run_mode_r);

  dae_tick_counter #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en_s),
    .clr  (tick_clr_s),
    .tc   (tick_tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; stop has priority over everything else.
  always_comb begin
    state_s = state_r;
    if (stop) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = start ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: state_s = ST_WAIT;
        ST_WAIT:  state_s = lat_done_s ? ST_PAUSE : ST_WAIT;
        ST_PAUSE: begin
          if (advance_s) begin
            state_s = (pc_r == prog_last) ? ST_DONE : ST_ISSUE;
          end else begin
            state_s = ST_PAUSE;
          end
        end
        ST_DONE:  state_s = start ? ST_ISSUE : ST_DONE;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode: datapath strobes, all suppressed by stop.
  always_comb begin
    load_s   = 1'b0;
    sample_s = 1'b0;
    pc_clr_s = 1'b0;
    pc_inc_s = 1'b0;
    if (!stop) begin
      case (state_r)
        ST_IDLE:  pc_clr_s = start;
        ST_ISSUE: load_s   = 1'b1;
        ST_WAIT:  sample_s = lat_done_s;
        ST_PAUSE: pc_inc_s = advance_s && (pc_r != prog_last);
        ST_DONE:  pc_clr_s = start;
        default:  pc_clr_s = 1'b0;
      endcase
    end else begin
      pc_clr_s = 1'b0;
    end
  end

  // Program memory; cleared by reset so an unloaded slot reads as SUB 0,0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {INSTR_W{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Execution latency counter, counts edges spent in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_r <= {LW{1'b0}};
    end else if ((state_r == ST_WAIT) && !lat_done_s && !stop) begin
      lat_cnt_r <= lat_cnt_r + LW'(1'b1);
    end else begin
      lat_cnt_r <= {LW{1'b0}};
    end
  end

  // Issue/result datapath and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_mode_r     <= 1'b0;
      rs_r           <= 4'h0;
      rt_r           <= 4'h0;
      sel_r          <= 3'b000;
      issue_valid_r  <= 1'b0;
      result_r       <= 4'h0;
      result_valid_r <= 1'b0;
      pc_r           <= {AW{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      run_mode_r     <= run_mode;
      issue_valid_r  <= load_s;
      result_valid_r <= sample_s;
      if (load_s) begin
        sel_r <= instr_sel(mem_r[pc_r]);
        rs_r  <= instr_rs(mem_r[pc_r]);
        rt_r  <= instr_rt(mem_r[pc_r]);
      end else begin
        sel_r <= sel_r;
        rs_r  <= rs_r;
        rt_r  <= rt_r;
      end
      if (sample_s) begin
        result_r <= rd_in;
      end else begin
        result_r <= result_r;
      end
      if (pc_clr_s) begin
        pc_r <= {AW{1'b0}};
      end else if (pc_inc_s) begin
        pc_r <= pc_r + AW'(1'b1);
      end else begin
        pc_r <= pc_r;
      end
      busy_r <= (state_s == ST_ISSUE) || (state_s == ST_WAIT) || (state_s == ST_PAUSE);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign rs           = rs_r;
  assign rt           = rt_r;
  assign sel          = sel_r;
  assign issue_valid  = issue_valid_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign pc           = pc_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_dae_instr_issuer.sv
// tb_dae_instr_issuer: directed + randomized bench for dae_instr_issuer.
// The decode-and-execute unit is modelled with one register stage so that
// rd_in only reflects new operands EXEC_LAT cycles after issue.
module tb_dae_instr_issuer;
  import dae_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TICK  = 4;
  localparam int LAT   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [10:0]       wr_data;
  logic [AW-1:0]     prog_last;
  logic              start;
  logic              step;
  logic              run_mode;
  logic              stop;
  logic [3:0]        rd_in;
  logic [3:0]        rs;
  logic [3:0]        rt;
  logic [2:0]        sel;
  logic              issue_valid;
  logic [3:0]        result;
  logic              result_valid;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;

  int passed = 0;
  int total  = 0;
  logic [10:0] model_mem [DEPTH];
  logic [3:0]  last_res;
  logic [3:0]  env_q;

  dae_instr_issuer #(
    .DEPTH(DEPTH), .AW(AW), .TICK_CYCLES(TICK), .EXEC_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_last(prog_last), .start(start), .step(step), .run_mode(run_mode),
    .stop(stop), .rd_in(rd_in), .rs(rs), .rt(rt), .sel(sel),
    .issue_valid(issue_valid), .result(result), .result_valid(result_valid),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference decode-and-execute behaviour, straight from the opcode table.
  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic signed [3:0] sb;
    logic [3:0]        r;
    sb = b;
    r  = 4'h0;
    case (op)
      OP_SUB:  r = a - b;
      OP_ADD:  r = a + b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SRA:  r = sb >>> 1;
      OP_ROL:  r = {a[2:0], a[3]};
      OP_CLT:  r = {3'b101, (a < b)};
      OP_CEQ:  r = {3'b111, (a == b)};
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Decode-and-execute unit model: one registered stage.
  always_ff @(posedge clk) env_q <= ref_alu(sel, rs, rt);
  assign rd_in = env_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic write_slot(input int a, input logic [10:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  // Entered on the negedge where issue_valid is seen; leaves on result_valid.
  task automatic check_instr(input int p);
    logic [10:0] ins;
    int c;
    ins = model_mem[p];
    chk("sel", sel, ins[10:8]);
    chk("rs", rs, ins[7:4]);
    chk("rt", rt, ins[3:0]);
    chk("pc", pc, p);
    chk("busy_run", busy, 1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) chk("iv_pulse", issue_valid, 0);
    end while (!result_valid && c < 50);
    chk("res_lat", c, LAT);
    last_res = ref_alu(ins[10:8], ins[7:4], ins[3:0]);
    chk("result", result, last_res);
  endtask

  task automatic start_issue();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_iv0", issue_valid, 0);
    chk("start_busy", busy, 1);
    @(negedge clk);
    chk("start_iv1", issue_valid, 1);
  endtask

  task automatic run_prog(input bit mode_run, input int last);
    int c;
    run_mode  = mode_run;
    prog_last = AW'(last);
    start_issue();
    for (int p = 0; p <= last; p++) begin
      check_instr(p);
      if (!mode_run) begin
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        if (p == last) begin
          chk("step_done", done, 1);
          chk("step_busy", busy, 0);
        end else begin
          @(negedge clk);
          chk("step_iv", issue_valid, 1);
        end
      end else begin
        if (p == last) begin
          repeat (TICK - 1) @(negedge clk);
          chk("run_not_done", done, 0);
          @(negedge clk);
          chk("run_done", done, 1);
        end else begin
          c = 0;
          while (!issue_valid && c < 100) begin
            @(negedge clk);
            c++;
          end
          chk("run_spacing", LAT + c, LAT + 1 + TICK);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rv;
    int last;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 11'h000; prog_last = '0;
    start = 1'b0; step = 1'b0; run_mode = 1'b0; stop = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 11'h000;
    repeat (3) @(negedge clk);
    chk("rst_rs", rs, 0);
    chk("rst_sel", sel, 0);
    chk("rst_result", result, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD 3,4 in step mode.
    write_slot(0, {OP_ADD, 4'd3, 4'd4});
    run_prog(1'b0, 0);
    chk("add_value", result, 4'd7);

    // SUB / CLT / CEQ sequence, stepped.
    go_idle();
    write_slot(0, {OP_SUB, 4'd2, 4'd5});
    write_slot(1, {OP_CLT, 4'd2, 4'd5});
    write_slot(2, {OP_CEQ, 4'd9, 4'd9});
    run_prog(1'b0, 2);
    chk("ceq_value", result, 4'hF);

    // Run mode, three instructions.
    go_idle();
    write_slot(0, {OP_OR,  4'hA, 4'h5});
    write_slot(1, {OP_SRA, 4'h1, 4'h9});
    write_slot(2, {OP_ROL, 4'h9, 4'h0});
    run_prog(1'b1, 2);

    // stop together with step while in WAIT.
    go_idle();
    write_slot(0, {OP_ADD, 4'd1, 4'd2});
    run_mode = 1'b0; prog_last = '0;
    start_issue();
    stop = 1'b1; step = 1'b1;
    @(negedge clk);
    stop = 1'b0; step = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stop_no_rv", result_valid, 0);
      @(negedge clk);
    end
    chk("stop_result_held", result, last_res);
    chk("stop_rs_held", rs, 4'd1);
    chk("stop_rt_held", rt, 4'd2);
    chk("stop_pc_held", pc, 0);

    // wr_en and start while busy are ignored.
    write_slot(0, {OP_OR,  4'hC, 4'h3});
    write_slot(1, {OP_AND, 4'hE, 4'h7});
    run_mode = 1'b0; prog_last = AW'(1);
    start_issue();
    check_instr(0);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = {OP_ADD, 4'd1, 4'd1}; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    chk("busy_start_pc", pc, 0);
    chk("busy_start_iv", issue_valid, 0);
    chk("busy_start_busy", busy, 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("busy_iv", issue_valid, 1);
    check_instr(1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("busy_done", done, 1);
    go_idle();
    run_prog(1'b0, 1);

    // Randomized programs, alternating step and run mode.
    for (int it = 0; it < 4; it++) begin
      go_idle();
      for (int s = 0; s < DEPTH; s++) begin
        rv = $urandom();
        write_slot(s, rv[10:0]);
      end
      last = int'($urandom_range(1, DEPTH - 1));
      run_prog(it % 2 == 1, last);
    end

    // Asynchronous reset in PAUSE, then replay of the cleared program.
    go_idle();
    write_slot(0, {OP_ADD, 4'd5, 4'd6});
    run_mode = 1'b0; prog_last = '0;
    start_issue();
    check_instr(0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_rs", rs, 0);
    chk("arst_rt", rt, 0);
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pc", pc, 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 11'h000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(1'b0, 0);
    chk("replay_zero", result, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
